// File: rtl/cs_stack_param_if.sv
// Handshake and status bundle for the clip-and-split triangle stack.
// The stack side uses the slave modport; the producer/consumer side uses master.
interface cs_stack_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport slave (
        input  clear, push, pop, data_in,
        output data_out, out_valid, top, count, empty, full, overflow, underflow
    );

    modport master (
        output clear, push, pop, data_in,
        input  data_out, out_valid, top, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/cs_stack_param.sv
// Parametrised LIFO of triangle records with guarded push/pop, exchange/bypass,
// sticky overflow/underflow flags and a combinational top-of-stack peek.
module cs_stack_param #(
    parameter int DEPTH = 8,
    // Default matches a Triangle3D record: 3 vertices x 3 coords x 32 bits.
    parameter int WIDTH = 288,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    cs_stack_param_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_count_m1;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_push_idx;
    logic [WIDTH-1:0] w_top;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_count_m1 = r_count - 1'b1;
    // Both indices are only used when guarded (not empty / not full), so they
    // always fit in AW bits.
    assign w_top_idx  = AW'(w_count_m1);
    assign w_push_idx = AW'(r_count);

    always_comb begin
        w_top = '0;
        if (!w_empty) begin
            w_top = r_mem[w_top_idx];
        end
    end

    // Storage carries no reset; writes are suppressed under rst and clear.
    always_ff @(posedge clk) begin
        if (!rst && !bus.clear) begin
            if (bus.push && !bus.pop && !w_full) begin
                r_mem[w_push_idx] <= bus.data_in;
            end else if (bus.push && bus.pop && !w_empty) begin
                r_mem[w_top_idx] <= bus.data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.clear) begin
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                unique case ({bus.push, bus.pop})
                    2'b10: begin
                        if (w_full) r_overflow <= 1'b1;
                        else        r_count    <= r_count + 1'b1;
                    end
                    2'b01: begin
                        if (w_empty) begin
                            r_underflow <= 1'b1;
                        end else begin
                            r_data_out  <= r_mem[w_top_idx];
                            r_out_valid <= 1'b1;
                            r_count     <= w_count_m1;
                        end
                    end
                    2'b11: begin
                        // Exchange when occupied, straight bypass when empty.
                        r_data_out  <= w_empty ? bus.data_in : r_mem[w_top_idx];
                        r_out_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.out_valid = r_out_valid;
    assign bus.top       = w_top;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_cs_stack_param.sv
// Directed bench for cs_stack_param at DEPTH=4, WIDTH=8 with hand-computed expectations.
module tb_cs_stack_param;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cs_stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

    cs_stack_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given controls; returns 1 time unit after the edge.
    task automatic cyc(input logic r, input logic c, input logic pu, input logic po,
                       input logic [WIDTH-1:0] d);
        rst         = r;
        bus.clear   = c;
        bus.push    = pu;
        bus.pop     = po;
        bus.data_in = d;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        bus.clear   = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_top", 32'(bus.top), 0);
        chk("rst_ovalid", 32'(bus.out_valid), 0);
        chk("rst_dout", 32'(bus.data_out), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_udf", 32'(bus.underflow), 0);

        // Fill then drain in LIFO order
        push(8'h11); chk("p1_top", 32'(bus.top), 32'h11); chk("p1_cnt", 32'(bus.count), 1);
        chk("p1_empty", 32'(bus.empty), 0);
        push(8'h22); chk("p2_top", 32'(bus.top), 32'h22);
        push(8'h33); chk("p3_top", 32'(bus.top), 32'h33); chk("p3_full", 32'(bus.full), 0);
        push(8'h44); chk("p4_top", 32'(bus.top), 32'h44); chk("p4_full", 32'(bus.full), 1);
        chk("p4_cnt", 32'(bus.count), 4);
        pop(); chk("q1_dout", 32'(bus.data_out), 32'h44); chk("q1_ov", 32'(bus.out_valid), 1);
        chk("q1_top", 32'(bus.top), 32'h33); chk("q1_full", 32'(bus.full), 0);
        pop(); chk("q2_dout", 32'(bus.data_out), 32'h33); chk("q2_top", 32'(bus.top), 32'h22);
        pop(); chk("q3_dout", 32'(bus.data_out), 32'h22); chk("q3_top", 32'(bus.top), 32'h11);
        pop(); chk("q4_dout", 32'(bus.data_out), 32'h11); chk("q4_ov", 32'(bus.out_valid), 1);
        chk("q4_empty", 32'(bus.empty), 1); chk("q4_top", 32'(bus.top), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_ov", 32'(bus.out_valid), 0); chk("idle_dout", 32'(bus.data_out), 32'h11);

        // Overflow, then drain into underflow; flags sticky until clear
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55);
        chk("ovf_flag", 32'(bus.overflow), 1); chk("ovf_cnt", 32'(bus.count), 4);
        chk("ovf_top", 32'(bus.top), 32'h44);
        pop(); chk("d1_dout", 32'(bus.data_out), 32'h44);
        pop(); chk("d2_dout", 32'(bus.data_out), 32'h33);
        pop(); chk("d3_dout", 32'(bus.data_out), 32'h22);
        pop(); chk("d4_dout", 32'(bus.data_out), 32'h11); chk("d4_udf", 32'(bus.underflow), 0);
        pop(); chk("d5_udf", 32'(bus.underflow), 1); chk("d5_ov", 32'(bus.out_valid), 0);
        chk("d5_dout", 32'(bus.data_out), 32'h11); chk("d5_cnt", 32'(bus.count), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("sticky_ovf", 32'(bus.overflow), 1); chk("sticky_udf", 32'(bus.underflow), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("clr_ovf", 32'(bus.overflow), 0); chk("clr_udf", 32'(bus.underflow), 0);

        // Exchange on occupied stack, bypass on empty stack
        push(8'h11); push(8'h22);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
        chk("xch_dout", 32'(bus.data_out), 32'h22); chk("xch_ov", 32'(bus.out_valid), 1);
        chk("xch_cnt", 32'(bus.count), 2); chk("xch_top", 32'(bus.top), 32'h99);
        pop(); chk("xp1_dout", 32'(bus.data_out), 32'h99);
        pop(); chk("xp2_dout", 32'(bus.data_out), 32'h11); chk("xp2_empty", 32'(bus.empty), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        chk("byp_dout", 32'(bus.data_out), 32'h77); chk("byp_ov", 32'(bus.out_valid), 1);
        chk("byp_cnt", 32'(bus.count), 0); chk("byp_udf", 32'(bus.underflow), 0);
        chk("byp_top", 32'(bus.top), 0);

        // Exchange on a full stack does not overflow
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        chk("fx_dout", 32'(bus.data_out), 32'h44); chk("fx_cnt", 32'(bus.count), 4);
        chk("fx_top", 32'(bus.top), 32'hAA); chk("fx_ovf", 32'(bus.overflow), 0);

        // Clear beats push; data_out held
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        push(8'h01); push(8'h02); push(8'h03);
        chk("c3_cnt", 32'(bus.count), 3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        chk("clrp_cnt", 32'(bus.count), 0); chk("clrp_dout", 32'(bus.data_out), 32'h44);
        chk("clrp_empty", 32'(bus.empty), 1); chk("clrp_top", 32'(bus.top), 0);

        // Reset during a pop drops it
        push(8'h11);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("rp_ov", 32'(bus.out_valid), 0); chk("rp_cnt", 32'(bus.count), 0);
        chk("rp_dout", 32'(bus.data_out), 0); chk("rp_top", 32'(bus.top), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
